chien_root_search: RTL

Chien-search root finder for the BCH decoder in the GF(2^PARAM_M) error-correction datapath. It takes the error-locator polynomial sigma(x) from the key-equation stage and evaluates it at alpha^(-j) for every codeword position j = 0..PARAM_N-1, one position per cycle. Each root found is emitted as an error position on a valid/ready stream to the bit-flip corrector. When the sweep ends, it reports the root count and a decoding-failure flag.

---
 rtl/chien_root_search.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/chien_root_search.sv
// -----------------------------------------------------------------------------
// chien_root_search
//
// Chien-search root finder for a binary BCH decoder over GF(2^PARAM_M).
// The field is built from the trinomial x^PARAM_M + x^PARAM_ALPHA + 1 in
// polynomial basis. The error-locator polynomial sigma(x) is loaded on start.
// The block then evaluates sigma(alpha^-j) for j = 0..PARAM_N-1, one position
// per cycle. Every zero of sigma is reported as an error position on a
// valid/ready stream. After the sweep, the root count and a failure flag are
// published. The failure flag is set when the root count differs from the
// locator degree, or when sigma_0 is zero.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : one-cycle search request (sampled only while idle)
//   sigma_in   : locator coefficients, sigma_i at [i*PARAM_M +: PARAM_M]
//   sigma_deg  : degree of sigma, sampled together with start
//   busy       : search in progress (any state other than idle)
//   pos_valid  : error position available on pos_data
//   pos_ready  : consumer accepts pos_data
//   pos_data   : error position j
//   done       : one-cycle completion pulse
//   err_cnt    : number of roots found in the last search
//   fail       : last search failed
// -----------------------------------------------------------------------------
module chien_root_search #(
  parameter int PARAM_M      = 9,
  parameter int PARAM_ALPHA  = 4,
  parameter int PARAM_T      = 4,
  parameter int PARAM_N      = 511,
  parameter int PARAM_N_BITS = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [(PARAM_T+1)*PARAM_M-1:0]   sigma_in,
  input  logic [PARAM_N_BITS-1:0]          sigma_deg,
  output logic                             busy,
  output logic                             pos_valid,
  input  logic                             pos_ready,
  output logic [PARAM_N_BITS-1:0]          pos_data,
  output logic                             done,
  output logic [PARAM_N_BITS-1:0]          err_cnt,
  output logic                             fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [PARAM_N_BITS-1:0] LAST_POS = PARAM_N_BITS'(PARAM_N - 1);
  localparam logic [PARAM_N_BITS-1:0] ONE_NB   = PARAM_N_BITS'(1);

  // Multiply by alpha^-1. Because x^M = x^A + 1, x^-1 = x^(M-1) + x^(A-1).
  // So shift right, and fold bit 0 back into positions M-1 and A-1.
  function automatic logic [PARAM_M-1:0] mul_alpha_inv(input logic [PARAM_M-1:0] v);
    logic [PARAM_M-1:0] res;
    res                = v >> 1;
    res[PARAM_M-1]     = v[0];
    res[PARAM_ALPHA-1] = res[PARAM_ALPHA-1] ^ v[0];
    return res;
  endfunction

  // Multiply by alpha^-n for 0 <= n <= PARAM_T. This is a chain of single
  // steps, unrolled to a fixed depth.
  function automatic logic [PARAM_M-1:0] mul_alpha_inv_pow(input logic [PARAM_M-1:0] v,
                                                           input int n);
    logic [PARAM_M-1:0] res;
    res = v;
    for (int k = 0; k < PARAM_T; k++) begin
      if (k < n) begin
        res = mul_alpha_inv(res);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t                    state_q, state_d;
  logic [PARAM_M-1:0]        r_q    [0:PARAM_T];
  logic [PARAM_M-1:0]        r_d    [0:PARAM_T];
  logic [PARAM_M-1:0]        r_next [0:PARAM_T];
  logic [PARAM_N_BITS-1:0]   j_q, j_d;
  logic [PARAM_N_BITS-1:0]   err_cnt_q, err_cnt_d;
  logic                      fail_q, fail_d;
  logic [PARAM_N_BITS-1:0]   deg_q, deg_d;
  logic                      pos_valid_q, pos_valid_d;
  logic [PARAM_N_BITS-1:0]   pos_data_q, pos_data_d;
  logic [PARAM_M-1:0]        sum_s;
  logic                      slot_free_s;

  // Evaluate sigma at the current point and advance every term to the next one.
  always_comb begin
    sum_s = {PARAM_M{1'b0}};
    for (int i = 0; i <= PARAM_T; i++) begin
      sum_s     = sum_s ^ r_q[i];
      r_next[i] = mul_alpha_inv_pow(r_q[i], i);
    end
  end

  // Next-state logic for the sweep controller and the output slot.
  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    err_cnt_d   = err_cnt_q;
    fail_d      = fail_q;
    deg_d       = deg_q;
    pos_valid_d = pos_valid_q;
    pos_data_d  = pos_data_q;
    for (int i = 0; i <= PARAM_T; i++) begin
      r_d[i] = r_q[i];
    end
    // A step may overwrite the output slot only if the slot is empty or
    // being consumed in this cycle.
    slot_free_s = !pos_valid_q || pos_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i <= PARAM_T; i++) begin
            r_d[i] = sigma_in[i*PARAM_M +: PARAM_M];
          end
          j_d       = {PARAM_N_BITS{1'b0}};
          err_cnt_d = {PARAM_N_BITS{1'b0}};
          deg_d     = sigma_deg;
          if (sigma_in[PARAM_M-1:0] == {PARAM_M{1'b0}}) begin
            // A locator with a zero constant term is not valid. Skip the
            // sweep and report a failure.
            fail_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            fail_d  = 1'b0;
            state_d = ST_SEARCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEARCH: begin
        if (slot_free_s) begin
          if (sum_s == {PARAM_M{1'b0}}) begin
            pos_valid_d = 1'b1;
            pos_data_d  = j_q;
            err_cnt_d   = err_cnt_q + ONE_NB;
          end else begin
            pos_valid_d = 1'b0;
          end
          for (int i = 0; i <= PARAM_T; i++) begin
            r_d[i] = r_next[i];
          end
          if (j_q == LAST_POS) begin
            state_d = ST_DRAIN;
          end else begin
            j_d = j_q + ONE_NB;
          end
        end else begin
          state_d = ST_SEARCH;
        end
      end

      ST_DRAIN: begin
        if (slot_free_s) begin
          pos_valid_d = 1'b0;
          fail_d      = (err_cnt_q != deg_q);
          state_d     = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      j_q         <= {PARAM_N_BITS{1'b0}};
      err_cnt_q   <= {PARAM_N_BITS{1'b0}};
      fail_q      <= 1'b0;
      deg_q       <= {PARAM_N_BITS{1'b0}};
      pos_valid_q <= 1'b0;
      pos_data_q  <= {PARAM_N_BITS{1'b0}};
      for (int i = 0; i <= PARAM_T; i++) begin
        r_q[i] <= {PARAM_M{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      err_cnt_q   <= err_cnt_d;
      fail_q      <= fail_d;
      deg_q       <= deg_d;
      pos_valid_q <= pos_valid_d;
      pos_data_q  <= pos_data_d;
      for (int i = 0; i <= PARAM_T; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pos_valid = pos_valid_q;
  assign pos_data  = pos_data_q;
  assign err_cnt   = err_cnt_q;
  assign fail      = fail_q;

endmodule
